// File: rtl/bus_ram_ctrl_pkg.sv
// bus_ram_ctrl_pkg: bus direction encodings and controller FSM states
package bus_ram_ctrl_pkg;
  localparam logic IO_CTRL_READ  = 1'b0;
  localparam logic IO_CTRL_WRITE = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_RESP   = 3'd3,
    S_CLEAR  = 3'd4
  } state_e;
endpackage

// File: rtl/bus_ram_array.sv
// bus_ram_array: byte-enabled single-port synchronous RAM, read-first, one-cycle read
module bus_ram_array #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                                 clk,
  input  logic                                 en_i,
  input  logic                                 we_i,
  input  logic [DATA_WIDTH/8-1:0]              be_i,
  input  logic [(DEPTH > 1 ? $clog2(DEPTH) : 1)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]                wdata_i,
  output logic [DATA_WIDTH-1:0]                rdata_o
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk)
    if (en_i) begin
      for (int i = 0; i < DATA_WIDTH/8; i++)
        if (we_i && be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      rdata_q <= mem[addr_i];
    end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/bus_ram_ctrl.sv
// bus_ram_ctrl: bus RAM slave with wait states, byte enables, range check; RAM_CLEAR_EN zeroes the array after reset
module bus_ram_ctrl
  import bus_ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    ctrl,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    err,
  output logic                    busy
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);
  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0]         be_q;
  logic                  wr_q, ready_q, err_q, rd_q;
  logic                  in_range, clearing;
  logic [AW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  assign in_range = {1'b0, addr_q} < (ADDR_WIDTH + 1)'(DEPTH);
`ifdef RAM_CLEAR_EN
  localparam state_e RST_STATE = S_CLEAR;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  logic [ADDR_WIDTH-1:0] clr_q;
  assign clearing = state_q == S_CLEAR;
  assign ram_addr = AW'(clearing ? clr_q : addr_q);
`else
  localparam state_e RST_STATE = S_IDLE;
  assign clearing = 1'b0;
  assign ram_addr = AW'(addr_q);
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
`ifdef RAM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      case (state_q)
        S_IDLE:
          if (en) begin
            addr_q  <= addr;
            wr_q    <= ctrl == IO_CTRL_WRITE;
            wdata_q <= wdata;
            be_q    <= be;
            cnt_q   <= WAIT_LOAD;
            state_q <= WAIT_STATES > 0 ? S_WAIT : S_ACCESS;
          end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_q <= S_ACCESS;
        end
        // response flags are registered here so they line up with the RAM read data
        S_ACCESS: begin
          state_q <= S_RESP;
          ready_q <= 1'b1;
          err_q   <= !in_range;
          rd_q    <= !wr_q && in_range;
        end
        S_RESP: state_q <= S_IDLE;
`ifdef RAM_CLEAR_EN
        S_CLEAR: begin
          clr_q <= clr_q + 1'b1;
          if (clr_q == LAST) state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  bus_ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk    (clk),
    .en_i   (clearing || (state_q == S_ACCESS && in_range)),
    .we_i   (clearing || wr_q),
    .be_i   (clearing ? {BW{1'b1}} : be_q),
    .addr_i (ram_addr),
    .wdata_i(clearing ? {DATA_WIDTH{1'b0}} : wdata_q),
    .rdata_o(ram_rdata)
  );
  assign rdata = rd_q ? ram_rdata : '0;
  assign ready = ready_q;
  assign err   = err_q;
  // nothing is accepted while rst is held, and busy reads 0 during reset
  assign busy  = state_q != S_IDLE && !rst;
endmodule

// File: tb/tb_bus_ram_ctrl.sv
// tb_bus_ram_ctrl: vector table, reset/clear sequences and random traffic against a word-level memory model
module tb_bus_ram_ctrl;
  import bus_ram_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        en[3], ctrl[3], ready[3], err[3], busy[3];
  logic [9:0]  addr[3];
  logic [15:0] wdata[3], rdata[3];
  logic [1:0]  be[3];
  int dep[3] = '{1000, 1024, 16};
  int ws[3]  = '{0, 3, 0};
  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    bus_ram_ctrl #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (10),
      .DEPTH      (g == 0 ? 1000 : g == 1 ? 1024 : 16),
      .WAIT_STATES(g == 1 ? 3 : 0)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en[g]),
      .ctrl (ctrl[g]),
      .addr (addr[g]),
      .wdata(wdata[g]),
      .be   (be[g]),
      .rdata(rdata[g]),
      .ready(ready[g]),
      .err  (err[g]),
      .busy (busy[g])
    );
  end
  int total = 0;
  int bad = 0;
  logic [15:0] mem[3][1024];
  logic [1:0]  kn[3][1024];
  typedef struct {
    int d; bit wr; int a; logic [15:0] wd; logic [1:0] b;
    logic [15:0] rd; logic er; int lat;
  } vec_t;
  vec_t tv[14];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_idle(input int d);
    int n = 0;
    while (busy[d] && n < 3000) begin @(negedge clk); n++; end
    if (busy[d]) begin
      total++; bad++;
      $display("FAIL idle_wait dut%0d: busy still 1 after %0d cycles, expected 0", d, n);
    end
  endtask
  function automatic void model_reset();
`ifdef RAM_CLEAR_EN
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < dep[d]; a++) begin mem[d][a] = '0; kn[d][a] = 2'b11; end
`endif
  endfunction
  function automatic void mdl(input int d, input bit wr, input int a, input logic [15:0] wd,
                              input logic [1:0] b, output logic [15:0] e, output logic ee,
                              output logic [15:0] m);
    e = '0; ee = a >= dep[d]; m = 16'hFFFF;
    if (!ee && wr) begin
      for (int l = 0; l < 2; l++)
        if (b[l]) begin mem[d][a][8*l +: 8] = wd[8*l +: 8]; kn[d][a][l] = 1'b1; end
    end else if (!ee) begin
      e = mem[d][a];
      m = {{8{kn[d][a][1]}}, {8{kn[d][a][0]}}};
    end
  endfunction
  task automatic txn(input int d, input bit wr, input int a, input logic [15:0] wd,
                     input logic [1:0] b, output logic [15:0] rd, output logic er, output int lat);
    wait_idle(d);
    en[d] = 1'b1; ctrl[d] = wr ? IO_CTRL_WRITE : IO_CTRL_READ;
    addr[d] = 10'(a); wdata[d] = wd; be[d] = b;
    @(negedge clk);
    en[d] = 1'b0; lat = 1;
    while (!ready[d] && lat < 40) begin @(negedge clk); lat++; end
    rd = rdata[d]; er = err[d];
  endtask
  task automatic clear_window(output int cnt, output bit saw);
    cnt = 0; saw = 1'b0;
    while (busy[2] && cnt < 100) begin
      cnt++;
      if (ready[2]) saw = 1'b1;
      @(negedge clk);
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] rd, e, m, wd;
    logic er, ee;
    logic [1:0] b;
    int lat, cnt, last, first, busyc, d, a;
    bit wr, saw;
    tv[0]  = '{0, 1, 'h005, 16'hBEEF, 2'b11, 16'h0000, 1'b0, 2};
    tv[1]  = '{0, 0, 'h005, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 2};
    tv[2]  = '{0, 1, 'h010, 16'h1234, 2'b11, 16'h0000, 1'b0, 2};
    tv[3]  = '{0, 1, 'h010, 16'hAB00, 2'b10, 16'h0000, 1'b0, 2};
    tv[4]  = '{0, 0, 'h010, 16'h0000, 2'b00, 16'hAB34, 1'b0, 2};
    tv[5]  = '{0, 1, 'h010, 16'hFFFF, 2'b00, 16'h0000, 1'b0, 2};
    tv[6]  = '{0, 0, 'h010, 16'h0000, 2'b11, 16'hAB34, 1'b0, 2};
    tv[7]  = '{0, 1, 'h3E8, 16'h5555, 2'b11, 16'h0000, 1'b1, 2};
    tv[8]  = '{0, 0, 'h3E8, 16'h0000, 2'b00, 16'h0000, 1'b1, 2};
    tv[9]  = '{0, 1, 'h3E7, 16'hCAFE, 2'b11, 16'h0000, 1'b0, 2};
    tv[10] = '{0, 0, 'h3E7, 16'h0000, 2'b00, 16'hCAFE, 1'b0, 2};
    tv[11] = '{1, 1, 'h020, 16'h7777, 2'b11, 16'h0000, 1'b0, 5};
    tv[12] = '{1, 0, 'h020, 16'h0000, 2'b00, 16'h7777, 1'b0, 5};
    tv[13] = '{2, 1, 'h010, 16'h1111, 2'b11, 16'h0000, 1'b1, 2};
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; ctrl[i] = IO_CTRL_READ; addr[i] = '0; wdata[i] = '0; be[i] = '0;
      for (int j = 0; j < 1024; j++) kn[i][j] = 2'b00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready%0d", i), ready[i], 0);
      chk($sformatf("reset_err%0d", i), err[i], 0);
      chk($sformatf("reset_rdata%0d", i), rdata[i], 0);
      chk($sformatf("reset_busy%0d", i), busy[i], 0);
    end
    rst = 1'b0;
    model_reset();
    #1;
`ifndef RAM_CLEAR_EN
    for (int i = 0; i < 3; i++) chk($sformatf("post_reset_busy%0d", i), busy[i], 0);
`endif
    for (int i = 0; i < 14; i++) begin
      mdl(tv[i].d, tv[i].wr, tv[i].a, tv[i].wd, tv[i].b, e, ee, m);
      txn(tv[i].d, tv[i].wr, tv[i].a, tv[i].wd, tv[i].b, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("vec%0d_err", i), er, tv[i].er);
      chk($sformatf("vec%0d_latency", i), lat, tv[i].lat);
    end
    // rst during WAIT discards the pending write of 0x0F0F
    wait_idle(1);
    en[1] = 1'b1; ctrl[1] = IO_CTRL_WRITE; addr[1] = 10'h020; wdata[1] = 16'h0F0F; be[1] = 2'b11;
    @(negedge clk);
    en[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_ready", ready[1], 0);
    rst = 1'b0;
    model_reset();
    #1;
`ifndef RAM_CLEAR_EN
    chk("rst_wait_busy", busy[1], 0);
`endif
    mdl(1, 0, 'h020, 16'h0, 2'b00, e, ee, m);
    txn(1, 0, 'h020, 16'h0, 2'b00, rd, er, lat);
    chk("rst_wait_old_data", rd, e);
    chk("rst_wait_latency", lat, 5);
    // en held high on the 3-wait-state slave: one accept per 6 cycles, busy 5 of 6
    wait_idle(1);
    en[1] = 1'b1; ctrl[1] = IO_CTRL_READ; addr[1] = 10'h020;
    last = -1; first = -1; busyc = 0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      if (first >= 0 && c > first && c <= first + 30 && busy[1]) busyc++;
      if (ready[1]) begin
        if (last >= 0) chk("throughput_gap", c - last, 6);
        last = c;
        if (first < 0) first = c;
      end
    end
    en[1] = 1'b0;
    chk("throughput_busy_cycles", busyc, 25);
    for (int i = 0; i < 300; i++) begin
      d = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 1) ? $urandom_range(0, 15) : dep[d] - 4 + $urandom_range(0, 7);
      if (a > 1023) a = 1023;
      wd = 16'($urandom);
      b = 2'($urandom_range(0, 3));
      mdl(d, wr, a, wd, b, e, ee, m);
      txn(d, wr, a, wd, b, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", i), rd & m, e & m);
      chk($sformatf("rnd%0d_err", i), er, ee);
      chk($sformatf("rnd%0d_latency", i), lat, ws[d] + 2);
    end
`ifdef RAM_CLEAR_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en[2] = 1'b1; ctrl[2] = IO_CTRL_WRITE; addr[2] = '0; wdata[2] = 16'hFFFF; be[2] = 2'b11;
    #1;
    clear_window(cnt, saw);
    en[2] = 1'b0;
    model_reset();
    chk("clear_busy_cycles", cnt, 16);
    chk("clear_ignores_request", saw, 0);
    txn(2, 0, 'h000, 16'h0, 2'b00, rd, er, lat);
    chk("clear_word0", rd, 0);
    chk("clear_word0_err", er, 0);
    txn(2, 0, 'h00F, 16'h0, 2'b00, rd, er, lat);
    chk("clear_word15", rd, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    clear_window(cnt, saw);
    model_reset();
    chk("clear_restart_busy_cycles", cnt, 16);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
